mmc_pad_ctrl: RTL and testbench

- Registered, parametrised SD/MMC pad-control stage between mmc_tester and the board IOBUFs; replaces the top-level combinational tri-state muxing.
- Adds per-line open-drain drivers with an optional active pull-up "kick".
- Latches the data bus width so it cannot change mid-transfer.
- Gates the card clock enable glitch-free and synchronises pad inputs back to sys_clk.

---
 rtl/mmc_pad_pkg.sv | 12 +
 rtl/mmc_line_drv.sv | 54 +++++
 rtl/mmc_pad_ctrl.sv | 85 ++++++++
 tb/tb_mmc_pad_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mmc_pad_pkg.sv
// mmc_pad_pkg: shared line-state encoding and bus-size helpers for the SD/MMC pad stage
package mmc_pad_pkg;
  typedef enum logic [1:0] {LS_Z, LS_PP, LS_LO, LS_KICK} line_state_e;
  localparam logic [1:0] SIZ_1BIT = 2'd0;
  localparam logic [1:0] SIZ_4BIT = 2'd1;
  localparam logic [1:0] SIZ_8BIT = 2'd2;
  function automatic int siz_to_width(logic [1:0] siz, int dat_width);
    int w;
    w = siz >= SIZ_8BIT ? 8 : siz == SIZ_4BIT ? 4 : 1;
    return w > dat_width ? dat_width : w;
  endfunction
endpackage

// File: rtl/mmc_line_drv.sv
// mmc_line_drv: registered push-pull/open-drain line driver with optional active pull-up kick
//   clk, rst : clock, synchronous active-high reset
//   en, od, d: line enable, open-drain mode, data
//   o, oe    : registered IOBUF value and enable
module mmc_line_drv
  import mmc_pad_pkg::*;
#(
  parameter int KICK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic od,
  input  logic d,
  output logic o,
  output logic oe
);
  localparam int CW = KICK_CYCLES > 1 ? $clog2(KICK_CYCLES) : 1;
  line_state_e st;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= LS_Z;
      cnt <= '0;
      o <= 1'b1;
      oe <= 1'b0;
    end else if (!en) begin
      st <= LS_Z;
      o <= 1'b1;
      oe <= 1'b0;
    end else if (!od) begin
      st <= LS_PP;
      o <= d;
      oe <= 1'b1;
    end else if (!d) begin
      st <= LS_LO;
      o <= 1'b0;
      oe <= 1'b1;
    end else if (st == LS_LO && KICK_CYCLES > 0) begin
      st <= LS_KICK;
      cnt <= CW'(KICK_CYCLES - 1);
      o <= 1'b1;
      oe <= 1'b1;
    end else if (st == LS_KICK && cnt != '0) begin
      cnt <= cnt - 1'b1;
      o <= 1'b1;
      oe <= 1'b1;
    end else begin
      st <= LS_Z;
      o <= 1'b1;
      oe <= 1'b0;
    end
  end
endmodule

// File: rtl/mmc_pad_ctrl.sv
// mmc_pad_ctrl: registered SD/MMC pad-control stage between the host core and the board IOBUFs
//   sys_clk, sys_rst              : clock, synchronous active-high reset
//   clk_i/clk_oe_i                : card clock and its enable request -> pad_clk_o/pad_clk_oe_o (glitch-free gate)
//   cmd_i/cmd_oe_i, dat_i/dat_oe_i: line values and enables -> pad_cmd_*/pad_dat_* via per-line drivers
//   od_mode_i, dat_siz_i          : open-drain mode, requested bus size (latched while idle)
//   pad_*_i -> *_sync_o           : pad inputs synchronised to sys_clk
//   siz_active_o, siz_pending_o   : applied bus size, deferred size change flag
module mmc_pad_ctrl
  import mmc_pad_pkg::*;
#(
  parameter int DAT_WIDTH   = 8,
  parameter int KICK_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 clk_i,
  input  logic                 clk_oe_i,
  input  logic                 cmd_i,
  input  logic                 cmd_oe_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic                 dat_oe_i,
  input  logic                 od_mode_i,
  input  logic [1:0]           dat_siz_i,
  output logic                 pad_clk_o,
  output logic                 pad_clk_oe_o,
  output logic                 pad_cmd_o,
  output logic                 pad_cmd_oe_o,
  output logic [DAT_WIDTH-1:0] pad_dat_o,
  output logic [DAT_WIDTH-1:0] pad_dat_oe_o,
  input  logic                 pad_clk_i,
  input  logic                 pad_cmd_i,
  input  logic [DAT_WIDTH-1:0] pad_dat_i,
  output logic                 clk_sync_o,
  output logic                 cmd_sync_o,
  output logic [DAT_WIDTH-1:0] dat_sync_o,
  output logic [1:0]           siz_active_o,
  output logic                 siz_pending_o
);
  localparam int NS = DAT_WIDTH + 2;
  int lane_w;
  logic [NS-1:0] sync_in, sync_out;
  assign lane_w = siz_to_width(siz_active_o, DAT_WIDTH);
  // Clock enable only moves while clk_i is low, so the gated clock never produces a runt high pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pad_clk_o <= 1'b0;
      pad_clk_oe_o <= 1'b0;
      siz_active_o <= SIZ_1BIT;
      siz_pending_o <= 1'b0;
    end else begin
      pad_clk_o <= clk_i;
      pad_clk_oe_o <= clk_i ? pad_clk_oe_o : clk_oe_i;
      siz_active_o <= dat_oe_i ? siz_active_o : dat_siz_i;
      siz_pending_o <= dat_oe_i && (dat_siz_i != siz_active_o);
    end
  end
  mmc_line_drv #(.KICK_CYCLES(KICK_CYCLES)) u_cmd (
    .clk(sys_clk), .rst(sys_rst), .en(cmd_oe_i), .od(od_mode_i), .d(cmd_i),
    .o(pad_cmd_o), .oe(pad_cmd_oe_o)
  );
  for (genvar k = 0; k < DAT_WIDTH; k++) begin : g_dat
    mmc_line_drv #(.KICK_CYCLES(KICK_CYCLES)) u_dat (
      .clk(sys_clk), .rst(sys_rst), .en(dat_oe_i && k < lane_w), .od(od_mode_i), .d(dat_i[k]),
      .o(pad_dat_o[k]), .oe(pad_dat_oe_o[k])
    );
  end
  assign sync_in = {pad_clk_i, pad_cmd_i, pad_dat_i};
  // Synchroniser flops idle high to match the pulled-up bus
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = sync_in;
  end else begin : g_sync
    logic [NS-1:0] sq [SYNC_STAGES];
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        for (int s = 0; s < SYNC_STAGES; s++) sq[s] <= '1;
      end else begin
        sq[0] <= sync_in;
        for (int s = 1; s < SYNC_STAGES; s++) sq[s] <= sq[s-1];
      end
    end
    assign sync_out = sq[SYNC_STAGES-1];
  end
  assign {clk_sync_o, cmd_sync_o, dat_sync_o} = sync_out;
endmodule

// File: tb/tb_mmc_pad_ctrl.sv
// tb_mmc_pad_ctrl: scoreboard bench for two pad-stage configurations (8/2/2 and 4/0/0)
module tb_mmc_pad_ctrl;
  logic sys_clk = 1'b0;
  logic sys_rst, clk_i, clk_oe_i, cmd_i, cmd_oe_i, dat_oe_i, od_mode_i, pad_clk_i, pad_cmd_i;
  logic [7:0] dat_i, pad_dat_i;
  logic [1:0] dat_siz_i;
  logic a_clk_o, a_clk_oe, a_cmd_o, a_cmd_oe, a_clk_s, a_cmd_s, a_pend;
  logic [7:0] a_dat_o, a_dat_oe, a_dat_s;
  logic [1:0] a_siz;
  logic b_clk_o, b_clk_oe, b_cmd_o, b_cmd_oe, b_clk_s, b_cmd_s, b_pend;
  logic [3:0] b_dat_o, b_dat_oe, b_dat_s;
  logic [1:0] b_siz;
  logic [4:0] ls [2][9];
  logic m_clk_oe [2];
  logic [1:0] m_siz [2];
  logic [9:0] hq [$];
  logic [65:0] sb [$];
  logic [65:0] exp_v;
  logic [32:0] act_a, act_b;
  int vectors = 0, miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  mmc_pad_ctrl #(.DAT_WIDTH(8), .KICK_CYCLES(2), .SYNC_STAGES(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_i(clk_i), .clk_oe_i(clk_oe_i),
    .cmd_i(cmd_i), .cmd_oe_i(cmd_oe_i), .dat_i(dat_i), .dat_oe_i(dat_oe_i),
    .od_mode_i(od_mode_i), .dat_siz_i(dat_siz_i),
    .pad_clk_o(a_clk_o), .pad_clk_oe_o(a_clk_oe), .pad_cmd_o(a_cmd_o), .pad_cmd_oe_o(a_cmd_oe),
    .pad_dat_o(a_dat_o), .pad_dat_oe_o(a_dat_oe),
    .pad_clk_i(pad_clk_i), .pad_cmd_i(pad_cmd_i), .pad_dat_i(pad_dat_i),
    .clk_sync_o(a_clk_s), .cmd_sync_o(a_cmd_s), .dat_sync_o(a_dat_s),
    .siz_active_o(a_siz), .siz_pending_o(a_pend)
  );

  mmc_pad_ctrl #(.DAT_WIDTH(4), .KICK_CYCLES(0), .SYNC_STAGES(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_i(clk_i), .clk_oe_i(clk_oe_i),
    .cmd_i(cmd_i), .cmd_oe_i(cmd_oe_i), .dat_i(dat_i[3:0]), .dat_oe_i(dat_oe_i),
    .od_mode_i(od_mode_i), .dat_siz_i(dat_siz_i),
    .pad_clk_o(b_clk_o), .pad_clk_oe_o(b_clk_oe), .pad_cmd_o(b_cmd_o), .pad_cmd_oe_o(b_cmd_oe),
    .pad_dat_o(b_dat_o), .pad_dat_oe_o(b_dat_oe),
    .pad_clk_i(pad_clk_i), .pad_cmd_i(pad_cmd_i), .pad_dat_i(pad_dat_i[3:0]),
    .clk_sync_o(b_clk_s), .cmd_sync_o(b_cmd_s), .dat_sync_o(b_dat_s),
    .siz_active_o(b_siz), .siz_pending_o(b_pend)
  );

  // Line model: st = {was_low, kick_left}; returns {o, oe, next st}
  function automatic logic [6:0] line_step(int k, logic [4:0] st, logic en, logic od, logic d);
    int kl;
    kl = st[4] ? k : int'(st[3:0]);
    if (!en) return 7'b10_00000;
    if (!od) return {d, 1'b1, 5'd0};
    if (!d) return {2'b01, 1'b1, 4'd0};
    if (kl > 0) return {2'b11, 1'b0, 4'(kl - 1)};
    return 7'b10_00000;
  endfunction

  task automatic tick();
    logic co, coe, mo, moe, pend;
    logic [7:0] dout, doe;
    logic [1:0] nsiz;
    logic [9:0] pin, sy, sv;
    logic [6:0] r;
    logic [32:0] e [2];
    int dw, kk, w;
    pin = {pad_clk_i, pad_cmd_i, pad_dat_i};
    if (sys_rst) begin
      hq.delete();
      hq.push_back(10'h3FF);
      sy = 10'h3FF;
    end else begin
      hq.push_back(pin);
      sy = hq.pop_front();
    end
    for (int i = 0; i < 2; i++) begin
      dw = i == 0 ? 8 : 4;
      kk = i == 0 ? 2 : 0;
      sv = i == 0 ? sy : (pin & 10'h30F);
      dout = '0;
      doe = '0;
      if (sys_rst) begin
        for (int l = 0; l < 9; l++) ls[i][l] = '0;
        co = 1'b0; coe = 1'b0; mo = 1'b1; moe = 1'b0;
        dout = dw == 8 ? 8'hFF : 8'h0F;
        nsiz = 2'd0; pend = 1'b0;
      end else begin
        co = clk_i;
        coe = clk_i ? m_clk_oe[i] : clk_oe_i;
        r = line_step(kk, ls[i][0], cmd_oe_i, od_mode_i, cmd_i);
        mo = r[6]; moe = r[5]; ls[i][0] = r[4:0];
        w = m_siz[i] == 2'd0 ? 1 : m_siz[i] == 2'd1 ? 4 : 8;
        if (w > dw) w = dw;
        for (int l = 0; l < dw; l++) begin
          r = line_step(kk, ls[i][l+1], dat_oe_i && l < w, od_mode_i, dat_i[l]);
          dout[l] = r[6]; doe[l] = r[5]; ls[i][l+1] = r[4:0];
        end
        pend = dat_oe_i && (dat_siz_i != m_siz[i]);
        nsiz = dat_oe_i ? m_siz[i] : dat_siz_i;
      end
      m_clk_oe[i] = coe;
      m_siz[i] = nsiz;
      e[i] = {co, coe, mo, moe, dout, doe, sv, nsiz, pend};
    end
    sb.push_back({e[0], e[1]});
    @(negedge sys_clk);
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act_a = {a_clk_o, a_clk_oe, a_cmd_o, a_cmd_oe, a_dat_o, a_dat_oe, a_clk_s, a_cmd_s, a_dat_s, a_siz, a_pend};
      act_b = {b_clk_o, b_clk_oe, b_cmd_o, b_cmd_oe, 4'h0, b_dat_o, 4'h0, b_dat_oe,
               b_clk_s, b_cmd_s, 4'h0, b_dat_s, b_siz, b_pend};
      vectors++;
      if (act_a !== exp_v[65:33]) begin
        miscompares++;
        $display("FAIL dut_a @%0t got %h want %h", $time, act_a, exp_v[65:33]);
      end
      vectors++;
      if (act_b !== exp_v[32:0]) begin
        miscompares++;
        $display("FAIL dut_b @%0t got %h want %h", $time, act_b, exp_v[32:0]);
      end
    end
  end

  initial begin
    sys_rst = 1'b1; clk_i = 1'b0; clk_oe_i = 1'b0; cmd_i = 1'b0; cmd_oe_i = 1'b0;
    dat_oe_i = 1'b0; od_mode_i = 1'b0; dat_siz_i = 2'd0; dat_i = '0;
    pad_clk_i = 1'b1; pad_cmd_i = 1'b1; pad_dat_i = '1;
    tick(); tick();
    sys_rst = 1'b0;
    od_mode_i = 1'b1; cmd_oe_i = 1'b1;
    cmd_i = 1'b0; tick();
    cmd_i = 1'b1; repeat (4) tick();
    cmd_i = 1'b0; tick();
    cmd_i = 1'b1; tick();
    cmd_i = 1'b0; tick();
    cmd_i = 1'b1; repeat (3) tick();
    dat_oe_i = 1'b0; dat_siz_i = 2'd1; tick();
    dat_oe_i = 1'b1; tick();
    dat_siz_i = 2'd2; repeat (2) tick();
    dat_oe_i = 1'b0; repeat (2) tick();
    od_mode_i = 1'b0; dat_oe_i = 1'b1; dat_i = 8'hAA; repeat (2) tick();
    clk_i = 1'b1; clk_oe_i = 1'b1; tick();
    clk_oe_i = 1'b0; tick();
    clk_oe_i = 1'b1; tick();
    clk_i = 1'b0; tick();
    clk_i = 1'b1; tick();
    clk_oe_i = 1'b0; repeat (2) tick();
    clk_i = 1'b0; tick();
    od_mode_i = 1'b1; cmd_i = 1'b0; dat_i = 8'h00; clk_oe_i = 1'b1; tick();
    cmd_i = 1'b1; dat_i = 8'hFF; clk_i = 1'b1; tick();
    sys_rst = 1'b1; tick();
    sys_rst = 1'b0; tick();
    for (int n = 0; n < 4000; n++) begin
      sys_rst = $urandom_range(0, 99) == 0;
      clk_i = 1'($urandom);
      clk_oe_i = $urandom_range(0, 3) != 0;
      cmd_i = 1'($urandom);
      cmd_oe_i = $urandom_range(0, 3) != 0;
      od_mode_i = $urandom_range(0, 3) != 0;
      dat_i = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dat_oe_i = ~dat_oe_i;
      if ($urandom_range(0, 3) == 0) dat_siz_i = 2'($urandom);
      pad_clk_i = 1'($urandom);
      pad_cmd_i = 1'($urandom);
      pad_dat_i = 8'($urandom);
      tick();
    end
    repeat (3) @(negedge sys_clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
